// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU op sequencer: MIPS funct codes, ALU control codes
// and the sequencer state encoding.
package alu_seq_pkg;

   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_MUL = 6'h18;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus ALU operand/result ports of the op sequencer.
// slave = sequencer side, master = requester and ALU side.
interface alu_op_sequencer_if #(parameter int DATA_W = 32);

   logic              req_valid_i;
   logic              req_ready_o;
   logic [5:0]        funct_i;
   logic [DATA_W-1:0] rs_data_i;
   logic [DATA_W-1:0] rt_data_i;
   logic [DATA_W-1:0] alu_data1_o;
   logic [DATA_W-1:0] alu_data2_o;
   logic [2:0]        alu_ctrl_o;
   logic [DATA_W-1:0] alu_result_i;
   logic              alu_zero_i;
   logic              resp_valid_o;
   logic [DATA_W-1:0] result_o;
   logic              zero_o;
   logic              illegal_o;

   modport slave (
      input  req_valid_i, funct_i, rs_data_i, rt_data_i, alu_result_i, alu_zero_i,
      output req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
             resp_valid_o, result_o, zero_o, illegal_o
   );

   modport master (
      output req_valid_i, funct_i, rs_data_i, rt_data_i, alu_result_i, alu_zero_i,
      input  req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
             resp_valid_o, result_o, zero_o, illegal_o
   );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational funct decoder. With ALU_SEQ_NATIVE_MUL_EN, mul maps to the ALU
// multiply code; otherwise it maps to add, the step op of the shift-add loop.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] ctrl,
   output logic       is_mul,
   output logic       illegal
);

   always_comb begin
      ctrl    = ALU_AND;
      is_mul  = 1'b0;
      illegal = 1'b0;
      case (funct)
         FUNCT_AND: ctrl = ALU_AND;
         FUNCT_OR:  ctrl = ALU_OR;
         FUNCT_ADD: ctrl = ALU_ADD;
         FUNCT_SUB: ctrl = ALU_SUB;
         FUNCT_MUL: begin
            is_mul = 1'b1;
`ifdef ALU_SEQ_NATIVE_MUL_EN
            ctrl = ALU_MUL;
`else
            ctrl = ALU_ADD;
`endif
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage initiator driving a combinational ALU from registers.
// ALU_SEQ_NATIVE_MUL_EN selects a one-shot native multiply instead of the shift-add loop.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MUL_ITERS = 32
)
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   alu_op_sequencer_if.slave bus
);

   state_e            state_reg, state_next;
   logic [DATA_W-1:0] data1_reg, data1_next;
   logic [DATA_W-1:0] data2_reg, data2_next;
   logic [2:0]        ctrl_reg, ctrl_next;
   logic              illegal_op_reg, illegal_op_next;
   logic [DATA_W-1:0] result_reg, result_next;
   logic              zero_reg, zero_next;
   logic              illegal_reg, illegal_next;

   logic [2:0]        dec_ctrl;
   logic              dec_is_mul;
   logic              dec_illegal;

`ifndef ALU_SEQ_NATIVE_MUL_EN
   localparam int CNT_W = $clog2(MUL_ITERS);
   // m is the multiplicand shifted to the current bit weight, q the remaining multiplier bits.
   logic [DATA_W-1:0] m_reg, m_next;
   logic [DATA_W-1:0] q_reg, q_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
`endif

   alu_seq_decode u_decode (
      .funct   (bus.funct_i),
      .ctrl    (dec_ctrl),
      .is_mul  (dec_is_mul),
      .illegal (dec_illegal)
   );

   always_comb begin
      state_next      = state_reg;
      data1_next      = data1_reg;
      data2_next      = data2_reg;
      ctrl_next       = ctrl_reg;
      illegal_op_next = illegal_op_reg;
      result_next     = result_reg;
      zero_next       = zero_reg;
      illegal_next    = illegal_reg;
`ifndef ALU_SEQ_NATIVE_MUL_EN
      m_next          = m_reg;
      q_next          = q_reg;
      cnt_next        = cnt_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               illegal_op_next = dec_illegal;
               state_next      = ST_EXEC;
               if (dec_illegal) begin
                  data1_next = '0;
                  data2_next = '0;
                  ctrl_next  = ALU_AND;
               end
`ifndef ALU_SEQ_NATIVE_MUL_EN
               else if (dec_is_mul) begin
                  data1_next = '0;
                  data2_next = bus.rt_data_i[0] ? bus.rs_data_i : '0;
                  ctrl_next  = ALU_ADD;
                  m_next     = bus.rs_data_i;
                  q_next     = bus.rt_data_i;
                  cnt_next   = '0;
                  state_next = ST_MUL;
               end
`endif
               else begin
                  data1_next = bus.rs_data_i;
                  data2_next = bus.rt_data_i;
                  ctrl_next  = dec_ctrl;
               end
            end
         end
         ST_EXEC: begin
            // An illegal op ran the ALU on idle values; its output is not reported.
            result_next  = illegal_op_reg ? '0 : bus.alu_result_i;
            zero_next    = !illegal_op_reg && bus.alu_zero_i;
            illegal_next = illegal_op_reg;
            data1_next   = '0;
            data2_next   = '0;
            ctrl_next    = ALU_AND;
            state_next   = ST_RESP;
         end
         ST_MUL: begin
`ifndef ALU_SEQ_NATIVE_MUL_EN
            m_next   = m_reg << 1;
            q_next   = q_reg >> 1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(MUL_ITERS - 1)) begin
               result_next  = bus.alu_result_i;
               zero_next    = bus.alu_zero_i;
               illegal_next = 1'b0;
               data1_next   = '0;
               data2_next   = '0;
               ctrl_next    = ALU_AND;
               state_next   = ST_RESP;
            end else begin
               // Feed the running sum back with the next partial product.
               data1_next = bus.alu_result_i;
               data2_next = q_reg[1] ? (m_reg << 1) : '0;
            end
`else
            state_next = ST_IDLE;
`endif
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg      <= ST_IDLE;
         data1_reg      <= '0;
         data2_reg      <= '0;
         ctrl_reg       <= ALU_AND;
         illegal_op_reg <= 1'b0;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
         illegal_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         data1_reg      <= data1_next;
         data2_reg      <= data2_next;
         ctrl_reg       <= ctrl_next;
         illegal_op_reg <= illegal_op_next;
         result_reg     <= result_next;
         zero_reg       <= zero_next;
         illegal_reg    <= illegal_next;
      end
   end

`ifndef ALU_SEQ_NATIVE_MUL_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_reg   <= '0;
         q_reg   <= '0;
         cnt_reg <= '0;
      end else begin
         m_reg   <= m_next;
         q_reg   <= q_next;
         cnt_reg <= cnt_next;
      end
   end
`endif

   assign bus.req_ready_o  = (state_reg == ST_IDLE);
   assign bus.resp_valid_o = (state_reg == ST_RESP);
   assign bus.alu_data1_o  = data1_reg;
   assign bus.alu_data2_o  = data2_reg;
   assign bus.alu_ctrl_o   = ctrl_reg;
   assign bus.result_o     = result_reg;
   assign bus.zero_o       = zero_reg;
   assign bus.illegal_o    = illegal_reg;

endmodule
